// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/decode/execute controller for the microprocessor core.
// Owns the program counter, addresses the instruction ROM, latches the
// instruction, resolves jmp/cjmp against a latched carry and pulses reg_we
// once per non-jump instruction. Adds run/step/halt control and a PC breakpoint.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   run, step         free-run level / single-instruction pulse
//   halt_req          stop at the next instruction boundary
//   bp_en, bp_addr    breakpoint enable and PC
//   rom_addr/rom_data ROM address out, registered ROM data in (1-cycle latency)
//   alu_cout          datapath carry, sampled in EXECUTE
//   inst, reg_we      latched instruction, register write enable
//   pc, halted        current PC, high while idle
//   retired           wrapping count of completed instructions
module exec_sequencer #(
  parameter int BIT_WIDTH  = 4,
  parameter int INST_WIDTH = BIT_WIDTH + 4,
  parameter int PC_WIDTH   = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  step,
  input  logic                  halt_req,
  input  logic                  bp_en,
  input  logic [PC_WIDTH-1:0]   bp_addr,
  output logic [PC_WIDTH-1:0]   rom_addr,
  input  logic [INST_WIDTH-1:0] rom_data,
  input  logic                  alu_cout,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  reg_we,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  carry_q, carry_d;
  logic                  bp_skip_q, bp_skip_d;
  logic                  step_mode_q, step_mode_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;

  logic                  is_jmp;
  logic                  is_cjmp;
  logic [PC_WIDTH-1:0]   target;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic                  run_ok;

  assign is_jmp  = inst_q[INST_WIDTH-1];
  assign is_cjmp = inst_q[INST_WIDTH-2];
  assign target  = inst_q[PC_WIDTH-1:0];
  assign pc_inc  = pc_q + 1'b1;
  assign run_ok  = run && !halt_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      inst_q      <= '0;
      carry_q     <= 1'b0;
      bp_skip_q   <= 1'b0;
      step_mode_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      carry_q     <= carry_d;
      bp_skip_q   <= bp_skip_d;
      step_mode_q <= step_mode_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    carry_d     = carry_q;
    bp_skip_d   = bp_skip_q;
    step_mode_d = step_mode_q;
    retired_d   = retired_q;
    reg_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // run wins over step; halt_req only gates run
        if (step || run_ok) begin
          state_d     = S_FETCH;
          step_mode_d = !run_ok;
          bp_skip_d   = 1'b1;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        inst_d  = rom_data;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_jmp) begin
          pc_d = target;
        end else if (is_cjmp) begin
          pc_d = carry_q ? target : pc_inc;
        end else begin
          reg_we  = 1'b1;
          pc_d    = pc_inc;
          carry_d = alu_cout;
        end
        retired_d = retired_q + 1'b1;
        bp_skip_d = 1'b0;
        // Breakpoint compares the PC about to be fetched; bp_skip lets the
        // first instruction after a resume run past its own breakpoint.
        if (halt_req || step_mode_q) begin
          state_d = S_IDLE;
        end else if (bp_en && (pc_d == bp_addr) && !bp_skip_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign halted   = (state_q == S_IDLE);
  assign retired  = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios plus randomized
// programs checked against an instruction-level reference model.
module tb_exec_sequencer;

  localparam int BW = 4;
  localparam int IW = BW + 4;
  localparam int PW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          step;
  logic          halt_req;
  logic          bp_en;
  logic [PW-1:0] bp_addr;
  logic [PW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic          alu_cout;
  logic [IW-1:0] inst;
  logic          reg_we;
  logic [PW-1:0] pc;
  logic          halted;
  logic [CW-1:0] retired;

  logic [IW-1:0] rom [16];
  logic          alu_tab [16];

  int n_checks = 0;
  int n_fail   = 0;
  int we_seen  = 0;

  exec_sequencer #(
    .BIT_WIDTH (BW),
    .INST_WIDTH(IW),
    .PC_WIDTH  (PW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .step    (step),
    .halt_req(halt_req),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .alu_cout(alu_cout),
    .inst    (inst),
    .reg_we  (reg_we),
    .pc      (pc),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  // Registered ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= rom[rom_addr];
  // Carry produced by the datapath for the instruction at the current PC
  assign alu_cout = alu_tab[rom_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] op_nop(input logic [3:0] lo);
    return {4'b0000, lo};
  endfunction

  function automatic logic [IW-1:0] op_jmp(input logic [3:0] t);
    return {4'b1000, t};
  endfunction

  function automatic logic [IW-1:0] op_cjmp(input logic [3:0] t);
    return {4'b0100, t};
  endfunction

  function automatic logic [IW-1:0] rand_inst();
    int unsigned r;
    logic [IW-1:0] v;
    r = $urandom_range(0, 9);
    v = IW'($urandom);
    if (r < 6)      v[IW-1:IW-2] = 2'b00;
    else if (r < 8) v[IW-1]      = 1'b1;
    else            v[IW-1:IW-2] = 2'b01;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (reg_we) we_seen++;
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 16; i++) begin
      rom[i]     = op_nop(4'($urandom));
      alu_tab[i] = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    run = 0; step = 0; halt_req = 0; bp_en = 0; bp_addr = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    we_seen = 0;
  endtask

  task automatic stop_run();
    int cnt;
    run = 0;
    halt_req = 1;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!halted && cnt < 8);
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_run: halted=%b after %0d cycles, required 1", halted, cnt);
    end
    halt_req = 0;
  endtask

  task automatic test_reset();
    fill_nops();
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted: got %b want 1", halted); end
    n_checks++;
    if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc); end
    n_checks++;
    if (we_seen !== 0) begin n_fail++; $display("FAIL reset_reg_we: %0d pulses want 0", we_seen); end
    n_checks++;
    if (retired !== 8'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
    n_checks++;
    if (inst !== 8'd0) begin n_fail++; $display("FAIL reset_inst: got %h want 00", inst); end
    n_checks++;
    if (rom_addr !== 4'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
  endtask

  task automatic test_free_run();
    int pc_bad;
    int we_bad;
    fill_nops();
    rom[3] = op_jmp(4'd0);
    do_reset();
    run = 1;
    pc_bad = 0;
    we_bad = 0;
    tick();  // first FETCH
    for (int i = 0; i < 24; i++) begin
      if (pc !== 4'((i / 3) % 4)) pc_bad++;
      if (reg_we !== ((i % 3 == 2) && ((i / 3) % 4 != 3))) we_bad++;
      if (i != 23) tick();
    end
    tick();
    n_checks++;
    if (pc_bad != 0) begin n_fail++; $display("FAIL free_run_pc_seq: %0d bad cycles want 0", pc_bad); end
    n_checks++;
    if (we_bad != 0) begin n_fail++; $display("FAIL free_run_we_timing: %0d bad cycles want 0", we_bad); end
    n_checks++;
    if (retired !== 8'd8) begin n_fail++; $display("FAIL free_run_retired: got %0d want 8", retired); end
    n_checks++;
    if (we_seen !== 6) begin n_fail++; $display("FAIL free_run_we_count: got %0d want 6", we_seen); end
    stop_run();
  endtask

  task automatic test_cjmp();
    for (int c = 0; c < 2; c++) begin
      fill_nops();
      rom[1] = op_cjmp(4'd5);
      alu_tab[0] = c[0];
      do_reset();
      run = 1;
      for (int i = 0; i < 7; i++) tick();
      n_checks++;
      if (pc !== (c == 1 ? 4'd5 : 4'd2)) begin
        n_fail++;
        $display("FAIL cjmp_carry%0d_pc: got %0d want %0d", c, pc, (c == 1 ? 5 : 2));
      end
      n_checks++;
      if (retired !== 8'd2) begin n_fail++; $display("FAIL cjmp_carry%0d_retired: got %0d want 2", c, retired); end
      stop_run();
    end
  endtask

  task automatic test_step();
    fill_nops();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step = 1;
      tick();
      step = 0;
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (halted !== 1'b1) begin n_fail++; $display("FAIL step%0d_halted: got %b want 1", k, halted); end
    end
    n_checks++;
    if (we_seen !== 3) begin n_fail++; $display("FAIL step_we_count: got %0d want 3", we_seen); end
    n_checks++;
    if (pc !== 4'd3) begin n_fail++; $display("FAIL step_pc: got %0d want 3", pc); end
    n_checks++;
    if (retired !== 8'd3) begin n_fail++; $display("FAIL step_retired: got %0d want 3", retired); end
  endtask

  task automatic test_breakpoint();
    int cnt;
    logic saw3;
    fill_nops();
    rom[3] = op_jmp(4'd2);
    do_reset();
    bp_en = 1;
    bp_addr = 4'd2;
    run = 1;
    cnt = 0;
    do begin tick(); cnt++; end while (!halted && cnt < 12);
    n_checks++;
    if (cnt !== 7) begin n_fail++; $display("FAIL bp_first_cycles: got %0d want 7", cnt); end
    n_checks++;
    if (pc !== 4'd2) begin n_fail++; $display("FAIL bp_first_pc: got %0d want 2", pc); end
    n_checks++;
    if (retired !== 8'd2) begin n_fail++; $display("FAIL bp_first_retired: got %0d want 2", retired); end
    we_seen = 0;
    saw3 = 0;
    cnt = 0;
    do begin tick(); cnt++; if (pc == 4'd3) saw3 = 1; end while (!halted && cnt < 12);
    n_checks++;
    if (saw3 !== 1'b1) begin n_fail++; $display("FAIL bp_resume_reach3: got %b want 1", saw3); end
    n_checks++;
    if (pc !== 4'd2) begin n_fail++; $display("FAIL bp_second_pc: got %0d want 2", pc); end
    n_checks++;
    if (retired !== 8'd4) begin n_fail++; $display("FAIL bp_second_retired: got %0d want 4", retired); end
    n_checks++;
    if (we_seen !== 1) begin n_fail++; $display("FAIL bp_resume_we: got %0d want 1", we_seen); end
    bp_en = 0;
    stop_run();
  endtask

  task automatic test_halt_mid();
    fill_nops();
    do_reset();
    run = 1;
    tick();  // FETCH
    tick();  // DECODE
    halt_req = 1;
    run = 0;
    tick();  // EXECUTE
    n_checks++;
    if (reg_we !== 1'b1) begin n_fail++; $display("FAIL halt_mid_we: got %b want 1", reg_we); end
    tick();
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_mid_halted: got %b want 1", halted); end
    n_checks++;
    if (pc !== 4'd1) begin n_fail++; $display("FAIL halt_mid_pc: got %0d want 1", pc); end
    n_checks++;
    if (retired !== 8'd1) begin n_fail++; $display("FAIL halt_mid_retired: got %0d want 1", retired); end
    halt_req = 0;
  endtask

  task automatic test_reset_mid();
    fill_nops();
    do_reset();
    run = 1;
    tick();
    tick();
    tick();  // EXECUTE
    n_checks++;
    if (reg_we !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_we: got %b want 1", reg_we); end
    rst = 1;
    #1;
    n_checks++;
    if (reg_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we: got %b want 0", reg_we); end
    n_checks++;
    if (pc !== 4'd0) begin n_fail++; $display("FAIL rst_mid_pc: got %0d want 0", pc); end
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL rst_mid_halted: got %b want 1", halted); end
    run = 0;
    tick();
    rst = 0;
  endtask

  // Instruction-level model: each instruction takes 3 cycles (4 when resuming
  // from idle); a breakpoint stops before fetching bp_addr unless just resumed.
  task automatic test_random();
    logic [PW-1:0] mpc, npc, tgt;
    logic          mcarry, ewe, exp_halt, resumed;
    logic [CW-1:0] mret, prev;
    logic [IW-1:0] cur;
    int            cnt, fails_before;
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i]     = rand_inst();
        alu_tab[i] = 1'($urandom);
      end
      do_reset();
      bp_en   = (round % 2 == 1);
      bp_addr = 4'($urandom);
      run = 1;
      mpc = '0; mcarry = 0; mret = '0; resumed = 1;
      fails_before = n_fail;
      for (int k = 0; k < 30; k++) begin
        cur = rom[mpc];
        tgt = cur[PW-1:0];
        ewe = 0;
        if (cur[IW-1])      npc = tgt;
        else if (cur[IW-2]) npc = mcarry ? tgt : mpc + 4'd1;
        else begin
          npc = mpc + 4'd1;
          ewe = 1;
          mcarry = alu_tab[mpc];
        end
        mret = mret + 8'd1;
        exp_halt = bp_en && (npc == bp_addr) && !resumed;

        we_seen = 0;
        prev = retired;
        cnt = 0;
        do begin tick(); cnt++; end while (retired == prev && cnt < 8);
        n_checks++;
        if (retired == prev) begin
          n_fail++;
          $display("FAIL rand_retire_timeout: r%0d i%0d no retire in %0d cycles", round, k, cnt);
          break;
        end
        n_checks++;
        if (cnt != (resumed ? 4 : 3)) begin n_fail++; $display("FAIL rand_cycles: r%0d i%0d got %0d want %0d", round, k, cnt, (resumed ? 4 : 3)); end
        n_checks++;
        if (inst !== cur) begin n_fail++; $display("FAIL rand_inst: r%0d i%0d got %h want %h", round, k, inst, cur); end
        n_checks++;
        if (pc !== npc) begin n_fail++; $display("FAIL rand_pc: r%0d i%0d got %0d want %0d", round, k, pc, npc); end
        n_checks++;
        if (we_seen !== int'(ewe)) begin n_fail++; $display("FAIL rand_we: r%0d i%0d got %0d want %0d", round, k, we_seen, ewe); end
        n_checks++;
        if (retired !== mret) begin n_fail++; $display("FAIL rand_retired: r%0d i%0d got %0d want %0d", round, k, retired, mret); end
        n_checks++;
        if (halted !== exp_halt) begin n_fail++; $display("FAIL rand_bp_halt: r%0d i%0d got %b want %b", round, k, halted, exp_halt); end
        resumed = exp_halt;
        mpc = npc;
        if (n_fail != fails_before) break;
      end
      bp_en = 0;
      stop_run();
    end
  endtask

  initial begin
    run = 0; step = 0; halt_req = 0; bp_en = 0; bp_addr = '0; rst = 1;
    test_reset();
    test_free_run();
    test_cjmp();
    test_step();
    test_breakpoint();
    test_halt_mid();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
